// File: rtl/bus_arbiter.sv
// N-master shared-bus arbiter: fixed-priority or round-robin selection, a parked
// default owner, an optional hold limit, and a private master-0 read path.
module bus_arbiter #(
    parameter int unsigned MASTERS  = 2,
    parameter int unsigned AW       = 16,
    parameter int unsigned DW       = 8,
    parameter int unsigned MODE     = 0,
    parameter int unsigned DEFAULT  = 0,
    parameter int unsigned MAX_HOLD = 0
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [MASTERS-1:0]      m_req,
    input  logic [MASTERS*AW-1:0]   m_address,
    input  logic [MASTERS*DW-1:0]   m_outdata,
    input  logic [MASTERS-1:0]      m_load,
    input  logic [MASTERS-1:0]      m_store,
    output logic [MASTERS*DW-1:0]   m_indata,
    output logic [MASTERS-1:0]      m_grant,
    output logic [AW-1:0]           bus_address,
    output logic [DW-1:0]           bus_outdata,
    output logic                    bus_load,
    output logic                    bus_store,
    input  logic [DW-1:0]           bus_data,
    input  logic [DW-1:0]           priv_data,
    output logic [2:0]              downer
);

    localparam int unsigned IW = 3;
    localparam int unsigned HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [IW-1:0] DEF_IDX  = IW'(DEFAULT);
    localparam logic [IW-1:0] RR_INIT  = IW'((DEFAULT + 1) % MASTERS);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    if (MASTERS < 2 || MASTERS > 8 || DEFAULT >= MASTERS) begin : g_bad_params
        $error("bus_arbiter: MASTERS must be 2..8 and DEFAULT < MASTERS");
    end

    logic [IW-1:0]      owner_q, owner_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [MASTERS-1:0] grant_d;

    // Lowest-index requester; MSB of the result flags that one was found.
    function automatic logic [IW:0] pick_fixed(input logic [MASTERS-1:0] req);
        logic [IW:0] r;
        r = '0;
        for (int unsigned i = 0; i < MASTERS; i++) begin
            if (req[i] && !r[IW]) r = {1'b1, IW'(i)};
        end
        return r;
    endfunction

    // First requester at or above start, else wrap to the lowest requester.
    function automatic logic [IW:0] pick_rr(input logic [MASTERS-1:0] req,
                                            input logic [IW-1:0]      start);
        logic [IW:0] hi;
        logic [IW:0] lo;
        hi = '0;
        lo = '0;
        for (int unsigned i = 0; i < MASTERS; i++) begin
            if (req[i]) begin
                if (!lo[IW]) lo = {1'b1, IW'(i)};
                if (!hi[IW] && (IW'(i) >= start)) hi = {1'b1, IW'(i)};
            end
        end
        return hi[IW] ? hi : lo;
    endfunction

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        return (32'(idx) == MASTERS - 1) ? '0 : idx + IW'(1);
    endfunction

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            owner_q <= DEF_IDX;
            rr_q    <= RR_INIT;
            hold_q  <= '0;
            m_grant <= MASTERS'(1) << DEF_IDX;
            downer  <= DEF_IDX;
        end else begin
            owner_q <= owner_d;
            rr_q    <= rr_d;
            hold_q  <= hold_d;
            m_grant <= grant_d;
            downer  <= owner_d;
        end
    end

    // Next-state: release / keep / expiry decision and hold accounting
    logic [MASTERS-1:0] own_oh;
    logic [MASTERS-1:0] others;
    logic               owner_req;
    logic               expired;
    logic [IW:0]        pick;

    always_comb begin
        owner_d   = owner_q;
        rr_d      = rr_q;
        hold_d    = hold_q;
        own_oh    = MASTERS'(1) << owner_q;
        others    = m_req & ~own_oh;
        owner_req = |(m_req & own_oh);
        expired   = (MAX_HOLD != 0) && (hold_q == HOLD_MAX) && (|others);
        pick      = (MODE == 1) ? pick_rr(others, rr_q) : pick_fixed(others);

        if (!owner_req || expired) begin
            if (pick[IW])     owner_d = pick[IW-1:0];
            else if (expired) owner_d = owner_q;
            else              owner_d = DEF_IDX;
        end

        if ((MODE == 1) && (owner_d != owner_q)) rr_d = next_idx(owner_d);

        if ((owner_d != owner_q) || !(|others)) hold_d = '0;
        else if (hold_q != HOLD_MAX)            hold_d = hold_q + HW'(1);

        grant_d = MASTERS'(1) << owner_d;
    end

    // Bus steering and read return, combinational from the owner register
    always_comb begin
        bus_address = '0;
        bus_outdata = '0;
        bus_load    = 1'b0;
        bus_store   = 1'b0;
        m_indata    = '0;
        for (int unsigned i = 0; i < MASTERS; i++) begin
            if (owner_q == IW'(i)) begin
                bus_address              = m_address[i*AW +: AW];
                bus_outdata              = m_outdata[i*DW +: DW];
                bus_load                 = m_load[i];
                bus_store                = m_store[i];
                m_indata[i*DW +: DW]     = bus_data;
            end
        end
        // Master 0's private HRAM/IE path bypasses arbitration entirely.
        m_indata[DW-1:0] = m_indata[DW-1:0] | priv_data;
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: three parameterisations sharing clock and reset.
module tb_bus_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;

    logic clock  = 1'b0;
    logic resetn = 1'b1;
    always #5 clock = ~clock;

    // a: 2 masters, fixed priority, no hold limit
    logic [1:0]      a_req, a_load, a_store, a_grant;
    logic [2*AW-1:0] a_address;
    logic [2*DW-1:0] a_outdata, a_indata;
    logic [AW-1:0]   a_bus_address;
    logic [DW-1:0]   a_bus_outdata, a_bus_data, a_priv_data;
    logic            a_bus_load, a_bus_store;
    logic [2:0]      a_downer;

    // b: 3 masters, round-robin, hold limit 4
    logic [2:0]      b_req, b_load, b_store, b_grant;
    logic [3*AW-1:0] b_address;
    logic [3*DW-1:0] b_outdata, b_indata;
    logic [AW-1:0]   b_bus_address;
    logic [DW-1:0]   b_bus_outdata, b_bus_data, b_priv_data;
    logic            b_bus_load, b_bus_store;
    logic [2:0]      b_downer;

    // c: 3 masters, fixed priority, no hold limit
    logic [2:0]      c_req, c_load, c_store, c_grant;
    logic [3*AW-1:0] c_address;
    logic [3*DW-1:0] c_outdata, c_indata;
    logic [AW-1:0]   c_bus_address;
    logic [DW-1:0]   c_bus_outdata, c_bus_data, c_priv_data;
    logic            c_bus_load, c_bus_store;
    logic [2:0]      c_downer;

    bus_arbiter #(.MASTERS(2), .AW(AW), .DW(DW), .MODE(0), .DEFAULT(0), .MAX_HOLD(0)) u_dut2 (
        .clock(clock), .resetn(resetn), .m_req(a_req), .m_address(a_address),
        .m_outdata(a_outdata), .m_load(a_load), .m_store(a_store), .m_indata(a_indata),
        .m_grant(a_grant), .bus_address(a_bus_address), .bus_outdata(a_bus_outdata),
        .bus_load(a_bus_load), .bus_store(a_bus_store), .bus_data(a_bus_data),
        .priv_data(a_priv_data), .downer(a_downer));

    bus_arbiter #(.MASTERS(3), .AW(AW), .DW(DW), .MODE(1), .DEFAULT(0), .MAX_HOLD(4)) u_dut3 (
        .clock(clock), .resetn(resetn), .m_req(b_req), .m_address(b_address),
        .m_outdata(b_outdata), .m_load(b_load), .m_store(b_store), .m_indata(b_indata),
        .m_grant(b_grant), .bus_address(b_bus_address), .bus_outdata(b_bus_outdata),
        .bus_load(b_bus_load), .bus_store(b_bus_store), .bus_data(b_bus_data),
        .priv_data(b_priv_data), .downer(b_downer));

    bus_arbiter #(.MASTERS(3), .AW(AW), .DW(DW), .MODE(0), .DEFAULT(0), .MAX_HOLD(0)) u_dut4 (
        .clock(clock), .resetn(resetn), .m_req(c_req), .m_address(c_address),
        .m_outdata(c_outdata), .m_load(c_load), .m_store(c_store), .m_indata(c_indata),
        .m_grant(c_grant), .bus_address(c_bus_address), .bus_outdata(c_bus_outdata),
        .bus_load(c_bus_load), .bus_store(c_bus_store), .bus_data(c_bus_data),
        .priv_data(c_priv_data), .downer(c_downer));

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t         sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] got);
        sb_t e;
        if (sb_q.size() == 0) begin
            check("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, got, e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        a_req = '0; a_load = 2'b01; a_store = '0;
        a_address = {16'hC000, 16'h0150}; a_outdata = {8'h22, 8'h11};
        a_bus_data = 8'hA5; a_priv_data = 8'h3C;
        b_req = '0; b_load = '0; b_store = '0; b_address = '0; b_outdata = '0;
        b_bus_data = '0; b_priv_data = '0;
        c_req = '0; c_load = '0; c_store = '0; c_address = '0; c_outdata = '0;
        c_bus_data = '0; c_priv_data = '0;

        // Reset: default owner 0 drives the bus
        #1 resetn = 1'b0;
        #1;
        check("rst_grant", 32'(a_grant), 32'h1);
        check("rst_bus_address", 32'(a_bus_address), 32'h0150);
        check("rst_bus_load", 32'(a_bus_load), 32'h1);
        check("rst_bus_outdata", 32'(a_bus_outdata), 32'h11);
        check("rst_indata1", 32'(a_indata[15:8]), 32'h0);
        check("rst_indata0", 32'(a_indata[7:0]), 32'hBD);
        check("rst_downer", 32'(a_downer), 32'h0);
        check("rst_grant_b", 32'(b_grant), 32'h1);
        @(negedge clock);
        resetn = 1'b1;
        repeat (3) tick();

        // Master 1 requests on a parked bus; master 0 keeps its private read
        a_address = {16'hC000, 16'hFF85};
        a_load    = 2'b11;
        a_req     = 2'b10;
        #1;
        check("park_grant_pre", 32'(a_grant), 32'h1);
        sb_push("req1_grant", 32'h2);
        tick();
        sb_pop(32'(a_grant));
        check("req1_bus_address", 32'(a_bus_address), 32'hC000);
        check("req1_bus_outdata", 32'(a_bus_outdata), 32'h22);
        check("req1_indata1", 32'(a_indata[15:8]), 32'hA5);
        check("req1_indata0_priv", 32'(a_indata[7:0]), 32'h3C);
        check("req1_downer", 32'(a_downer), 32'h1);

        // DMA burst: no hold limit, master 1 keeps the bus despite master 0
        a_req = 2'b11;
        for (int k = 0; k < 160; k++) begin
            sb_push("burst_grant", 32'h2);
            tick();
            sb_pop(32'(a_grant));
        end
        a_req = 2'b01;
        sb_push("burst_return", 32'h1);
        tick();
        sb_pop(32'(a_grant));
        check("burst_return_addr", 32'(a_bus_address), 32'hFF85);

        // Reset mid-burst with owner 1 snaps back to default without a clock
        a_req = 2'b10;
        sb_push("reburst_grant", 32'h2);
        tick();
        sb_pop(32'(a_grant));
        a_req   = 2'b11;
        a_store = 2'b01;
        #1;
        check("reburst_store_hidden", 32'(a_bus_store), 32'h0);
        #1 resetn = 1'b0;
        #1;
        check("async_grant", 32'(a_grant), 32'h1);
        check("async_bus_store", 32'(a_bus_store), 32'h1);
        check("async_downer", 32'(a_downer), 32'h0);
        check("async_hold", 32'(u_dut2.hold_q), 32'h0);
        check("async_rr", 32'(u_dut2.rr_q), 32'h1);
        @(negedge clock);
        a_req = '0; a_store = '0;
        resetn = 1'b1;
        tick();

        // Round-robin with hold limit 4: five-cycle tenures 0,1,2,0,1
        b_req = 3'b111;
        #1;
        check("rr_grant_0", 32'(b_grant), 32'h1);
        check("rr_hold_0", 32'(u_dut3.hold_q), 32'h0);
        for (int k = 1; k <= 20; k++) begin
            sb_push("rr_grant", 32'h1 << ((k / 5) % 3));
            tick();
            sb_pop(32'(b_grant));
            check("rr_hold", 32'(u_dut3.hold_q), 32'(k % 5));
        end
        b_req = '0;

        // Fixed priority: simultaneous requests on release resolve by index
        c_req = 3'b001;
        tick();
        c_req = 3'b110;
        for (int k = 0; k < 3; k++) begin
            sb_push("fp_grant1", 32'h2);
            tick();
            sb_pop(32'(c_grant));
        end
        c_req = 3'b100;
        sb_push("fp_grant2", 32'h4);
        tick();
        sb_pop(32'(c_grant));
        c_req = 3'b000;
        sb_push("fp_park", 32'h1);
        tick();
        sb_pop(32'(c_grant));

        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Parametrised N-master arbiter for the shared system bus.
- Generalises the fixed CPU/DMA steering in the top level: any number of masters, a fixed-priority or round-robin mode, a parked default owner, and a hold limit that bounds bus ownership.
- Slaves stay OR-combined on the bus. Master 0 keeps a private read path (HRAM, IE) that bypasses arbitration.

Parameters:
- MASTERS, 2, number of masters (2..8); index 0 is the CPU.
- AW, 16, address width.
- DW, 8, data width.
- MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
- DEFAULT, 0, master that owns the bus when nobody requests.
- MAX_HOLD, 0, maximum consecutive owned cycles while another master waits; 0 disables the limit.

Ports:
- clock  in  1  bus clock; all state changes on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- m_req  in  MASTERS  per-master bus request.
- m_address  in  MASTERS*AW  packed addresses; master i occupies bits [i*AW +: AW].
- m_outdata  in  MASTERS*DW  packed write data.
- m_load  in  MASTERS  per-master read strobe.
- m_store  in  MASTERS  per-master write strobe.
- m_indata  out  MASTERS*DW  packed read data returned to each master.
- m_grant  out  MASTERS  one-hot ownership, registered.
- bus_address  out  AW  to slaves.
- bus_outdata  out  DW  to slaves.
- bus_load  out  1  to slaves.
- bus_store  out  1  to slaves.
- bus_data  in  DW  OR of all slave read data.
- priv_data  in  DW  master-0 private read data (HRAM/IE).
- downer  out  3  current owner index, for the debug display.

Behaviour:
- State:
  - owner register, reset to DEFAULT; m_grant = one-hot(owner); downer = owner.
  - rr pointer, reset to DEFAULT+1 mod MASTERS.
  - hold counter, width clog2(MAX_HOLD+1), reset 0.
- Bus drive (combinational from owner):
  - bus_address, bus_outdata, bus_load and bus_store mirror the owner's signals.
  - Non-owners' load/store never reach the bus.
- Read return:
  - m_indata[owner] = bus_data.
  - m_indata[0] additionally ORs priv_data in every cycle, owned or not.
  - All other non-owner slots = 0.
- Reset: owner = DEFAULT, so bus outputs follow DEFAULT's inputs; all non-DEFAULT m_indata = 0.
- Arbitration, evaluated every edge:
  - Release: owner's m_req low at the edge.
  - Keep: owner's m_req high and hold not expired.
  - Expired: MAX_HOLD != 0, hold == MAX_HOLD and at least one other m_req is high.
  - On release or expiry, next owner:
    - MODE 0: lowest-index requesting master other than the current owner. If none, the current owner on expiry; DEFAULT on release.
    - MODE 1: first requester searching upward from rr with wrap-around, excluding the current owner. If none, same fallback as MODE 0.
    - When ownership changes in MODE 1, rr = new owner + 1 mod MASTERS.
  - The DEFAULT master may hold the bus without m_req only while no other m_req is high. Any other request takes the bus at the next edge, treated as a release.
- Latency:
  - m_req rising in cycle n on an idle or parked bus → m_grant at edge n+1, and that master's strobes appear on the bus in cycle n+1.
  - Handover costs no dead cycle.
- Hold counter:
  - Increments while the owner keeps the bus and some other m_req is high; saturates at MAX_HOLD.
  - Clears to 0 on every ownership change and whenever no other master requests.
- Masters must hold address and strobes stable until m_grant is seen. A strobe pulse given without grant is lost; this is not an error.
- Simultaneous requests plus release in MODE 0 resolve purely by index. Ties never occur in MODE 1 because the pointer ordering decides.
- Reset mid-transfer: ownership snaps to DEFAULT asynchronously and the bus strobes switch to DEFAULT's inputs immediately.
- Width rules:
  - Packed-vector slices use fixed-stride indexed part-selects.
  - downer is zero-extended.
  - MASTERS > 8 is illegal and must trip a generate-time error.

Test Plan:
- Reset with MASTERS=2, DEFAULT=0, m_load[0]=1, m_address[0]=16'h0150 → m_grant=2'b01, bus_address=16'h0150, bus_load=1; m_indata[1]=0.
- MODE 0: m_req[1] rises in cycle 5 while master 0 is parked without a request → m_grant=2'b10 at edge 6. bus_address equals master 1's 16'hC000 in cycle 6. Master 0's read of 16'hFF85 still returns priv_data=8'h3C while bus_data is routed to master 1.
- MODE 1, MASTERS=3, all m_req held high, MAX_HOLD=4 → owner sequence 0,1,2,0 with each tenure exactly 5 cycles; hold count 0..4 then switch.
- MAX_HOLD=0, master 1 requests for 160 cycles (DMA burst) while m_req[0]=1 → m_grant=2'b10 for all 160 cycles, then returns to 2'b01 on the edge after m_req[1] falls.
- resetn asserted low mid-burst with owner=1 → m_grant=2'b01 and bus_store follows m_store[0] without waiting for a clock; hold=0 and rr=1 after release.
- MODE 0, m_req[1] and m_req[2] both rise as owner 0 releases → grant to 1; grant goes to 2 only once m_req[1] falls.
